// File: rtl/edge_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module   : edge_detect_pkg
// Purpose  : Shared definitions for the streaming 3x3 edge-detection engine:
//            accumulator width derivation, mode bit positions, stage control
//            record and the output clamp / absolute-value helper.
// Revision : 1.0 - initial release
// ============================================================================
package edge_detect_pkg;

    // Bit positions inside the 2-bit mode word.
    localparam int KERNEL_4N = 0;   // 0: 8-neighbour kernel, 1: 4-neighbour
    localparam int OUT_ABS   = 1;   // 0: clamp, 1: |acc| then clamp

    // Widest pixel the clamp helper supports; the helper works at this
    // width and callers truncate to their own PIX_W.
    localparam int MAX_PIX_W = 32;
    localparam int MAX_ACC_W = MAX_PIX_W + 4;

    // Control travelling alongside the window through the first stage.
    typedef struct packed {
        logic       valid;
        logic       last;
        logic [1:0] mode;
    } stage_ctl_t;

    // 8*(2^P-1) needs P+3 magnitude bits; one more for the sign.
    function automatic int acc_width(input int pix_w);
        return pix_w + 4;
    endfunction

    // Column/row counter width, never below one bit.
    function automatic int col_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Optional absolute value, then saturate into [0, 2^pix_w - 1].
    function automatic logic [MAX_PIX_W-1:0] clamp_pix(
        input logic signed [MAX_ACC_W-1:0] acc,
        input logic                        abs_en,
        input int                          pix_w
    );
        logic signed [MAX_ACC_W-1:0] v;
        logic signed [MAX_ACC_W-1:0] lim;
        lim = $signed((MAX_ACC_W'(1) << pix_w) - MAX_ACC_W'(1));
        v   = (abs_en && acc[MAX_ACC_W-1]) ? -acc : acc;
        if (v[MAX_ACC_W-1]) begin
            v = '0;
        end else if (v > lim) begin
            v = lim;
        end
        return v[MAX_PIX_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : line_buffer
// Purpose  : One video line of storage (IMG_W entries) addressed by the shared
//            column counter. The write lands at the column of the pixel being
//            accepted; the registered read is issued one cycle ahead at the
//            column of the next pixel, so rd_data already holds the previous
//            line's value for that column when the pixel arrives.
// Ports    : clk      - clock
//            wr_en    - a pixel is accepted this cycle
//            wr_col   - column of the accepted pixel
//            rd_col   - column of the next pixel to be accepted
//            wr_data  - value stored at wr_col
//            rd_data  - registered read of the previous line at rd_col
// Revision : 1.0 - initial release
// ============================================================================
module line_buffer
    import edge_detect_pkg::*;
#(
    parameter int PIX_W = 16,
    parameter int IMG_W = 320
) (
    input  logic                           clk,
    input  logic                           wr_en,
    input  logic [col_width(IMG_W)-1:0]    wr_col,
    input  logic [col_width(IMG_W)-1:0]    rd_col,
    input  logic [PIX_W-1:0]               wr_data,
    output logic [PIX_W-1:0]               rd_data
);

    logic [PIX_W-1:0] r_mem [IMG_W];
    logic [PIX_W-1:0] r_rd_q;

    // rd_col never equals wr_col in the same cycle (the next column always
    // differs from the current one for IMG_W >= 3), so no bypass is needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_col] <= wr_data;
        end
        r_rd_q <= r_mem[rd_col];
    end

    assign rd_data = r_rd_q;

endmodule
`default_nettype wire

// File: rtl/edge_detect_stream.sv
`default_nettype none
// ============================================================================
// Module   : edge_detect_stream
// Purpose  : Raster-order streaming 3x3 edge detector with valid/ready on both
//            sides. Emits only interior pixels; 3-stage pipeline
//            (window / kernel sum / clamp) that freezes as a whole while the
//            output is stalled.
// Ports    : clk, reset_n            - clock, async active-low reset
//            mode[1:0]              - bit0 4-neighbour kernel, bit1 abs output
//            in_data/in_valid/in_sof/in_ready   - input pixel stream
//            out_data/out_valid/out_last/out_ready - filtered output stream
// Revision : 1.0 - initial release
// ============================================================================
module edge_detect_stream
    import edge_detect_pkg::*;
#(
    parameter int PIX_W = 16,
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       mode,
    input  logic [PIX_W-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic             in_ready,
    output logic [PIX_W-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready
);

    localparam int ACC_W = acc_width(PIX_W);
    localparam int COL_W = col_width(IMG_W);
    localparam int ROW_W = col_width(IMG_H);
    localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] C_ROW_LAST = ROW_W'(IMG_H - 1);

    logic                    w_stall;
    logic                    w_accept;
    logic [COL_W-1:0]        r_col;
    logic [ROW_W-1:0]        r_row;
    logic [COL_W-1:0]        w_pos_col;
    logic [ROW_W-1:0]        w_pos_row;
    logic [COL_W-1:0]        w_nxt_col;
    logic [ROW_W-1:0]        w_nxt_row;
    logic [COL_W-1:0]        w_rd_col;
    logic [1:0]              r_mode;
    logic [PIX_W-1:0]        w_lb0_q;
    logic [PIX_W-1:0]        w_lb1_q;
    logic [PIX_W-1:0]        w_win_in [3];
    logic [PIX_W-1:0]        r_win    [3][3];
    stage_ctl_t              r_s1;
    logic signed [ACC_W-1:0] w_p      [3][3];
    logic signed [ACC_W-1:0] w_sum4;
    logic signed [ACC_W-1:0] w_sum8;
    logic signed [ACC_W-1:0] w_kernel;
    logic signed [ACC_W-1:0] r_s2_acc;
    logic                    r_s2_valid;
    logic                    r_s2_last;
    logic                    r_s2_abs;
    logic                    r_out_valid;
    logic                    r_out_last;
    logic [PIX_W-1:0]        r_out_data;

    // Any held output freezes every stage, including acceptance.
    assign w_stall  = r_out_valid && !out_ready;
    assign in_ready = !w_stall;
    assign w_accept = in_valid && !w_stall;

    // Position of the pixel on the input this cycle; in_sof overrides the
    // counters, which also covers in_sof coinciding with a row wrap.
    always_comb begin
        w_pos_col = in_sof ? '0 : r_col;
        w_pos_row = in_sof ? '0 : r_row;
        w_nxt_col = w_pos_col + COL_W'(1);
        w_nxt_row = w_pos_row;
        if (w_pos_col == C_COL_LAST) begin
            w_nxt_col = '0;
            w_nxt_row = (w_pos_row == C_ROW_LAST) ? '0 : w_pos_row + ROW_W'(1);
        end
        w_rd_col = w_accept ? w_nxt_col : r_col;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_col  <= '0;
            r_row  <= '0;
            r_mode <= '0;
        end else if (w_accept) begin
            r_col <= w_nxt_col;
            r_row <= w_nxt_row;
            if ((w_pos_col == '0) && (w_pos_row == '0)) begin
                r_mode <= mode;
            end
        end
    end

    // Line buffer 0 holds row r-1; its output is pushed into buffer 1,
    // which therefore holds row r-2.
    line_buffer #(.PIX_W(PIX_W), .IMG_W(IMG_W)) u_lb0 (
        .clk     (clk),
        .wr_en   (w_accept),
        .wr_col  (w_pos_col),
        .rd_col  (w_rd_col),
        .wr_data (in_data),
        .rd_data (w_lb0_q)
    );

    line_buffer #(.PIX_W(PIX_W), .IMG_W(IMG_W)) u_lb1 (
        .clk     (clk),
        .wr_en   (w_accept),
        .wr_col  (w_pos_col),
        .rd_col  (w_rd_col),
        .wr_data (w_lb0_q),
        .rd_data (w_lb1_q)
    );

    // Window rows: 0 = r-2, 1 = r-1, 2 = r. Columns: 0 = c-2 .. 2 = c.
    // Contents need no reset: stale columns are always shifted out before
    // an interior position (c >= 2) is reached.
    assign w_win_in[0] = w_lb1_q;
    assign w_win_in[1] = w_lb0_q;
    assign w_win_in[2] = in_data;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < 3; i++) begin
                r_win[i][0] <= r_win[i][1];
                r_win[i][1] <= r_win[i][2];
                r_win[i][2] <= w_win_in[i];
            end
        end
    end

    // Stage 1 control: the window now centres on (r-1, c-1).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= '0;
        end else if (!w_stall) begin
            r_s1.valid <= w_accept && (w_pos_row >= ROW_W'(2)) && (w_pos_col >= COL_W'(2));
            r_s1.last  <= (w_pos_row == C_ROW_LAST) && (w_pos_col == C_COL_LAST);
            r_s1.mode  <= r_mode;
        end
    end

    // Stage 2: kernel sum on zero-extended pixels.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w_p[i][j] = $signed({{(ACC_W-PIX_W){1'b0}}, r_win[i][j]});
            end
        end
        w_sum4 = w_p[0][1] + w_p[2][1] + w_p[1][0] + w_p[1][2];
        w_sum8 = w_sum4 + w_p[0][0] + w_p[0][2] + w_p[2][0] + w_p[2][2];
        if (r_s1.mode[KERNEL_4N]) begin
            w_kernel = (w_p[1][1] <<< 2) - w_sum4;
        end else begin
            w_kernel = (w_p[1][1] <<< 3) - w_sum8;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_abs   <= 1'b0;
            r_s2_acc   <= '0;
        end else if (!w_stall) begin
            r_s2_valid <= r_s1.valid;
            r_s2_last  <= r_s1.last;
            r_s2_abs   <= r_s1.mode[OUT_ABS];
            r_s2_acc   <= w_kernel;
        end
    end

    // Stage 3: clamp into the output register; held while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else if (!w_stall) begin
            r_out_valid <= r_s2_valid;
            r_out_last  <= r_s2_valid && r_s2_last;
            if (r_s2_valid) begin
                r_out_data <= PIX_W'(clamp_pix(MAX_ACC_W'(r_s2_acc), r_s2_abs, PIX_W));
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: doc/edge_detect_stream.md
# edge_detect_stream

Streaming 3x3 edge-detection engine for the Nios II video path. It replaces the nine-register, command-strobed kernel with a raster-order pixel stream that has valid/ready handshakes on both sides. It uses internal line buffers, generic pixel width and frame size, and a run-time selectable kernel and output mode. Input comes from the frame reader; output goes to the frame writer or an Avalon-ST adapter.

## Interface
- PIX_W, 16: unsigned pixel width in bits.
- IMG_W, 320: pixels per line (≥3).
- IMG_H, 240: lines per frame (≥3).
- clk  in  1  sole clock; all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- mode  in  2  bit0: kernel (0 = 8-neighbour, 1 = 4-neighbour); bit1: output (0 = clamp, 1 = absolute value then clamp).
- in_data  in  PIX_W  input pixel, raster order.
- in_valid  in  1  in_data valid.
- in_sof  in  1  qualifies the first pixel of a frame; forces position (0,0).
- in_ready  out  1  block accepts the pixel this cycle.
- out_data  out  PIX_W  filtered pixel.
- out_valid  out  1  out_data valid.
- out_last  out  1  with out_valid: last output pixel of the frame.
- out_ready  in  1  sink accepts the output this cycle.

## Operation
- A pixel is accepted when in_valid && in_ready. A col/row counter tracks the position (r,c) of each accepted pixel.
- Column wraps at IMG_W-1, which increments the row. Row wraps at IMG_H-1 back to 0 (the next frame starts without in_sof).
- in_sof with an accepted pixel forces that pixel to (0,0), discarding the partial frame. Pixels already in flight still drain.
- Two line buffers (depth IMG_W) hold rows r-1 and r-2. A 3x3 window shift register is fed by in_data and both buffer outputs at column c.
- Only interior pixels are emitted. An accepted pixel at r≥2, c≥2 produces the output for centre (r-1,c-1). Each frame emits (IMG_W-2)*(IMG_H-2) pixels, with no border output.
- Kernels, computed in signed ACC_W = PIX_W+4 bits:
  - mode bit0 = 0: 8*P5 − sum of 8 neighbours.
  - mode bit0 = 1: 4*P5 − (N+S+E+W).
- Output stage:
  - mode bit1 = 0: negative → 0; >2^PIX_W−1 → 2^PIX_W−1.
  - mode bit1 = 1: |acc|, then clamp to 2^PIX_W−1.
- mode is sampled on acceptance of pixel (0,0) and held for the whole frame. Mid-frame changes take effect at the next frame.
- out_last asserts with the output for centre (IMG_H-2, IMG_W-2).

## Timing
- 3-stage pipeline:
  - S1: accept, window shift, line-buffer write/read.
  - S2: kernel sum.
  - S3: clamp, output register.
- With out_ready held high, out_valid rises 3 cycles after the triggering pixel is accepted.
- Sustained throughput is 1 pixel/cycle.
- Stall = out_valid && !out_ready. in_ready = !stall (combinational), and all stages freeze while stalled.
- out_data and out_last hold stable while out_valid && !out_ready.
- Bubbles (non-emitting positions, in_valid low) propagate as invalid stage slots. No output is generated for them.
- Reset values:
  - out_valid = 0, out_data = 0, out_last = 0.
  - All stage valids = 0, counters = (0,0), latched mode = 0.
  - in_ready = 1 after reset.
  - Line-buffer and window contents are not reset; they are never emitted before being overwritten.
- Reset asserted mid-frame: in-flight outputs are discarded immediately, and the next accepted pixel is (0,0).
- in_sof and the row wrap on the same pixel: the result is (0,0), with no double count.

## Structure
- Package edge_detect_pkg holds:
  - the ACC_W derivation;
  - mode bit constants: KERNEL_4N, OUT_ABS;
  - the clamp/abs function.
- Sub-module line_buffer (parameters PIX_W and IMG_W): single-port-per-cycle circular RAM with a registered read and shared column address. It is instantiated twice; the output of the first feeds the input of the second.

## Test plan
- Use PIX_W = 8, IMG_W = 4, IMG_H = 4 for all cases.
- Flat frame, all 50, mode 0 → exactly 4 outputs, all 0. out_last on the 4th.
- Single 10 at (1,1), rest 0:
  - mode 0 → centre (1,1) outputs 80; (1,2), (2,1), (2,2) output 0.
  - mode 2 → 80, 10, 10, 10.
- 255 at (1,1), rest 0, mode 0 → 2040 clamped to 255.
- Same frame with mode 1 (4-neighbour) → 1020 clamped to 255; (2,2) outputs 0.
- out_ready low for 5 cycles mid-frame:
  - in_ready low for the same cycles;
  - out_data held;
  - no output lost or duplicated; output stream identical to the unstalled run.
- Back-to-back frames:
  - mode change mid-frame takes effect at the next frame.
  - in_sof pulsed at (2,1) → counters restart, and the following 16 pixels produce a correct 4-output frame.
  - reset_n pulsed mid-frame → out_valid drops immediately, and the next frame is correct.
